// File: rtl/checksum_calc_if.sv
// checksum_calc_if: bundles the packet stream ports and the checksum FIFO push port.
// Ports: s_din/s_valid/s_rdy are the input stream, m_dout/m_valid/m_rdy the output stream,
//   csum_data/csum_valid/csum_full the checksum FIFO side. slave = checksum_calc, master = its environment.
interface checksum_calc_if #(
  parameter int DATA_WIDTH = 73
);
  logic [DATA_WIDTH-1:0] s_din;
  logic                  s_valid;
  logic                  s_rdy;
  logic [DATA_WIDTH-1:0] m_dout;
  logic                  m_valid;
  logic                  m_rdy;
  logic [15:0]           csum_data;
  logic                  csum_valid;
  logic                  csum_full;

  modport slave (
    input  s_din, s_valid, m_rdy, csum_full,
    output s_rdy, m_dout, m_valid, csum_data, csum_valid
  );

  modport master (
    output s_din, s_valid, m_rdy, csum_full,
    input  s_rdy, m_dout, m_valid, csum_data, csum_valid
  );
endinterface

// File: rtl/checksum_calc.sv
// checksum_calc: passes the tx packet stream through a 2-entry skid buffer unchanged and pushes
//   one 16-bit TCP ones'-complement checksum per packet to the checksum FIFO, in packet order.
// Latency: data 1 cycle through an empty skid; checksum valid 2 cycles after the last-beat handshake.
// Backpressure: s_rdy drops when the skid holds 2 beats or csum_full is set; csum_valid is never held off.
// Ports: clk, rst (synchronous, active-high); bus (checksum_calc_if.slave) carries s_din/s_valid/s_rdy,
//   m_dout/m_valid/m_rdy and csum_data/csum_valid/csum_full. Beat: [72:9] data, [8:1] keep, [0] last.
// Build option: define CSUM_PSEUDO_HDR_EN to include the IPv4 (IHL=5) TCP pseudo-header in the sum.
module checksum_calc #(
  parameter int DATA_WIDTH = 73,
  parameter int CSUM_START = 34,
  parameter int CSUM_FIELD = 50
) (
  input logic            clk,
  input logic            rst,
  checksum_calc_if.slave bus
);

`ifdef CSUM_PSEUDO_HDR_EN
  // -20 in ones'-complement: turns the summed IP total length into the TCP length.
  localparam logic [15:0] PSEUDO_CONST = 16'hFFEB;

  // IP total length (16-17), protocol (23, lands in the low byte) and src/dst addresses (26-33).
  function automatic logic is_pseudo_hdr(input logic [5:0] off);
    return (off == 6'd16) || (off == 6'd17) || (off == 6'd23) ||
           ((off >= 6'd26) && (off <= 6'd33));
  endfunction
`else
  localparam logic [15:0] PSEUDO_CONST = 16'h0000;
`endif

  logic                  in_hs;
  logic                  out_hs;
  logic                  last_hs;
  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            skid_cnt;

  assign in_hs   = bus.s_valid && bus.s_rdy;
  assign out_hs  = bus.m_valid && bus.m_rdy;
  assign last_hs = in_hs && bus.s_din[0];

  assign bus.s_rdy   = !rst && (skid_cnt != 2'd2) && !bus.csum_full;
  assign bus.m_valid = (skid_cnt != 2'd0);
  assign bus.m_dout  = skid_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      skid_mem[0] <= '0;
      skid_mem[1] <= '0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      skid_cnt    <= 2'd0;
    end else begin
      if (in_hs) begin
        skid_mem[wr_ptr] <= bus.s_din;
        wr_ptr           <= !wr_ptr;
      end
      if (out_hs) begin
        rd_ptr <= !rd_ptr;
      end
      case ({in_hs, out_hs})
        2'b10:   skid_cnt <= skid_cnt + 2'd1;
        2'b01:   skid_cnt <= skid_cnt - 2'd1;
        default: ;
      endcase
    end
  end

  logic [2:0]  beat_cnt;
  logic [5:0]  lane_off;
  logic        lane_use;
  logic [7:0]  mbyte [8];
  logic [17:0] beatsum;
  logic [31:0] acc;
  logic [31:0] fin;
  logic        fin_vld;
  logic [16:0] f1;
  logic [15:0] f2;
  logic [15:0] csum_q;
  logic        csum_vld_q;

  // Lane offset = 8*beat + lane. Once the count saturates at 7 every lane sits at >= 56,
  // so beyond that point only keep can mask a byte.
  always_comb begin
    lane_off = '0;
    lane_use = 1'b0;
    for (int k = 0; k < 8; k++) begin
      lane_off = {beat_cnt, 3'(k)};
      lane_use = bus.s_din[k+1];
`ifdef CSUM_PSEUDO_HDR_EN
      if ((lane_off < 6'(CSUM_START)) && !is_pseudo_hdr(lane_off)) lane_use = 1'b0;
`else
      if (lane_off < 6'(CSUM_START)) lane_use = 1'b0;
`endif
      // The checksum field itself is always summed as zero.
      if ((lane_off == 6'(CSUM_FIELD)) || (lane_off == 6'(CSUM_FIELD + 1))) lane_use = 1'b0;
      mbyte[k] = lane_use ? bus.s_din[8*k+9 +: 8] : 8'h00;
    end
  end

  // Even lanes are the high byte of each 16-bit word (network byte order).
  assign beatsum = 18'({mbyte[0], mbyte[1]}) + 18'({mbyte[2], mbyte[3]}) +
                   18'({mbyte[4], mbyte[5]}) + 18'({mbyte[6], mbyte[7]});

  // Two folds are enough: the first leaves at most 0x1FFFE, the second cannot carry again.
  assign f1 = 17'(fin[15:0]) + 17'(fin[31:16]);
  assign f2 = f1[15:0] + 16'(f1[16]);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt   <= 3'd0;
      acc        <= '0;
      fin        <= '0;
      fin_vld    <= 1'b0;
      csum_q     <= '0;
      csum_vld_q <= 1'b0;
    end else begin
      if (in_hs) begin
        if (bus.s_din[0]) begin
          beat_cnt <= 3'd0;
          acc      <= '0;
          fin      <= acc + 32'(beatsum) + 32'(PSEUDO_CONST);
        end else begin
          if (beat_cnt != 3'd7) beat_cnt <= beat_cnt + 3'd1;
          acc <= acc + 32'(beatsum);
        end
      end
      // fin is consumed in the fold this cycle, so a last beat accepted now may refill it.
      fin_vld    <= last_hs;
      csum_vld_q <= fin_vld;
      if (fin_vld) csum_q <= ~f2;
    end
  end

  assign bus.csum_data  = csum_q;
  assign bus.csum_valid = csum_vld_q;

endmodule

// File: tb/tb_checksum_calc.sv
// tb_checksum_calc: directed packets for checksum_calc, checked against a packet-level
//   ones'-complement model plus hand-computed literals; one compare process checks every cycle.
// Ports: none (top-level bench); drives the DUT through a checksum_calc_if instance.
`timescale 1ns/1ps
module tb_checksum_calc;
  localparam int DW = 73;
`ifdef CSUM_PSEUDO_HDR_EN
  localparam bit PSEUDO = 1'b1;
`else
  localparam bit PSEUDO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  checksum_calc_if #(.DATA_WIDTH(DW)) bus ();
  checksum_calc dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int mode   = 0;
  int pulses = 0;
  logic [15:0]   last_csum = 16'h0;
  logic [7:0]    pkt [128];
  int            pkt_len = 0;
  logic [DW-1:0] exp_beats [$];
  logic [15:0]   exp_csum [$];
  int            exp_cyc [$];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_dout = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask
  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin n_fail++; $display("FAIL %s: got %b, expected %b", nm, act, exp); end
  endtask
  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin n_fail++; $display("FAIL %s: got 0x%04h, expected 0x%04h", nm, act, exp); end
  endtask
  task automatic chk_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin n_fail++; $display("FAIL %s: got %0d, expected %0d", nm, act, exp); end
  endtask
  task automatic chk_dat(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act !== exp) begin n_fail++; $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp); end
  endtask

  function automatic logic [15:0] pick(input logic [15:0] off_v, input logic [15:0] on_v);
    return PSEUDO ? on_v : off_v;
  endfunction

  // Which packet byte offsets belong to the checksummed region.
  function automatic bit byte_summed(input int o);
    if (o == 50 || o == 51) return 1'b0;
    if (o >= 34) return 1'b1;
    return PSEUDO && (o == 16 || o == 17 || o == 23 || (o >= 26 && o <= 33));
  endfunction

  // Packet-level model: end-around-carry sum over the whole byte array, then complement.
  function automatic logic [15:0] model_csum();
    logic [16:0] s = '0;
    logic [15:0] w;
    for (int o = 0; o < pkt_len; o++) begin
      if (byte_summed(o)) begin
        w = (o % 2 == 0) ? {pkt[o], 8'h00} : {8'h00, pkt[o]};
        s = 17'(s[15:0]) + 17'(w);
        s = 17'(s[15:0]) + 17'(s[16]);
      end
    end
    if (PSEUDO) begin
      s = 17'(s[15:0]) + 17'(16'hFFEB);
      s = 17'(s[15:0]) + 17'(s[16]);
    end
    return ~s[15:0];
  endfunction

  task automatic clear_pkt(input int len);
    for (int i = 0; i < 128; i++) pkt[i] = 8'h00;
    pkt_len = len;
  endtask

  // Presents one beat and returns #1 after the edge on which it was accepted.
  task automatic send_beat(input logic [DW-1:0] d, input bit is_last, input logic [15:0] ecs);
    int t = 0;
    bus.s_din   = d;
    bus.s_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.s_rdy === 1'b1) break;
      t++;
      if (t > 200) begin
        fail_now("s_rdy_wait");
        return;
      end
    end
    @(posedge clk);
    exp_beats.push_back(d);
    if (is_last) begin
      exp_csum.push_back(ecs);
      exp_cyc.push_back(cyc + 2);
    end
    #1;
  endtask

  // Sends the current packet (at most max_beats beats); unkept lanes carry 0xEE filler.
  task automatic send_pkt(input int max_beats);
    int nb = (pkt_len + 7) / 8;
    logic [15:0] ecs = model_csum();
    logic [DW-1:0] d;
    for (int b = 0; b < nb && b < max_beats; b++) begin
      d = '0;
      for (int k = 0; k < 8; k++) begin
        int o;
        o = 8 * b + k;
        if (o < pkt_len) begin
          d[8*k+9 +: 8] = pkt[o];
          d[k+1] = 1'b1;
        end else begin
          d[8*k+9 +: 8] = 8'hEE;
        end
      end
      d[0] = (b == nb - 1);
      send_beat(d, b == nb - 1, ecs);
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_beats.size() != 0 || exp_csum.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    if (exp_beats.size() != 0 || exp_csum.size() != 0) fail_now("drain");
    @(posedge clk);
    #1;
  endtask

  // Output-side stimulus: m_rdy toggles and csum_full pulses in mode 1.
  initial begin
    bus.m_rdy     = 1'b1;
    bus.csum_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mode == 1) begin
        bus.m_rdy     = ~bus.m_rdy;
        bus.csum_full = (cyc % 4 == 2);
      end else begin
        bus.m_rdy     = 1'b1;
        bus.csum_full = 1'b0;
      end
    end
  end

  // Single compare process.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (bus.csum_full) chk_bit("s_rdy_while_full", bus.s_rdy, 1'b0);
      if (prev_stall) begin
        chk_bit("hold_m_valid", bus.m_valid, 1'b1);
        chk_dat("hold_m_dout", bus.m_dout, prev_dout);
      end
      if (bus.m_valid && bus.m_rdy) begin
        if (exp_beats.size() == 0) fail_now("extra_beat");
        else chk_dat("m_dout", bus.m_dout, exp_beats.pop_front());
      end
      if (bus.csum_valid) begin
        pulses++;
        last_csum = bus.csum_data;
        if (exp_csum.size() == 0) begin
          fail_now("extra_csum_valid");
        end else begin
          chk16("csum_data", bus.csum_data, exp_csum.pop_front());
          chk_int("csum_latency", cyc, exp_cyc.pop_front());
        end
      end
      prev_stall = bus.m_valid && !bus.m_rdy;
      prev_dout  = bus.m_dout;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    bus.s_din   = '0;
    bus.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_bit("rst_s_rdy", bus.s_rdy, 1'b0);
    chk_bit("rst_m_valid", bus.m_valid, 1'b0);
    chk_dat("rst_m_dout", bus.m_dout, '0);
    chk_bit("rst_csum_valid", bus.csum_valid, 1'b0);
    chk16("rst_csum_data", bus.csum_data, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk_bit("s_rdy_after_rst", bus.s_rdy, 1'b1);
    @(posedge clk); #1;

    // 7 beats, one TCP word 0x1234.
    clear_pkt(56); pkt[34] = 8'h12; pkt[35] = 8'h34;
    chk16("model_t1", model_csum(), pick(16'hEDCB, 16'hEDDF));
    send_pkt(99); drain();
    chk16("t1_csum", last_csum, pick(16'hEDCB, 16'hEDDF));

    // Checksum field contents are ignored.
    clear_pkt(56); pkt[50] = 8'hFF; pkt[51] = 8'hFF;
    chk16("model_t2", model_csum(), pick(16'hFFFF, 16'h0014));
    send_pkt(99); drain();
    chk16("t2_csum", last_csum, pick(16'hFFFF, 16'h0014));

    // Carry fold (partial last beat), then a keep=0x01 beat at counter 7, back to back.
    clear_pkt(38); pkt[34] = 8'hFF; pkt[35] = 8'hFF; pkt[36] = 8'h00; pkt[37] = 8'h01;
    chk16("model_t3a", model_csum(), pick(16'hFFFE, 16'h0013));
    send_pkt(99);
    clear_pkt(57); pkt[56] = 8'hAB;
    chk16("model_t3b", model_csum(), pick(16'h54FF, 16'h5513));
    send_pkt(99); drain();
    chk16("t3b_csum", last_csum, pick(16'h54FF, 16'h5513));

    // Result of exactly zero is emitted unchanged.
    clear_pkt(40); pkt[34] = PSEUDO ? 8'h00 : 8'hFF; pkt[35] = PSEUDO ? 8'h14 : 8'hFF;
    send_pkt(99); drain();
    chk16("zero_csum", last_csum, 16'h0000);

    // Pseudo-header vector.
    clear_pkt(56); pkt[17] = 8'h28; pkt[23] = 8'h06;
    pkt[26] = 8'h0A; pkt[29] = 8'h01; pkt[30] = 8'h0A; pkt[33] = 8'h02;
    chk16("model_t4", model_csum(), pick(16'hFFFF, 16'hEBE2));
    send_pkt(99); drain();
    chk16("t4_csum", last_csum, pick(16'hFFFF, 16'hEBE2));

    // 10 beats: the counter saturates, bytes past 63 still count.
    clear_pkt(80); pkt[34] = 8'h10; pkt[72] = 8'h01; pkt[73] = 8'h02; pkt[79] = 8'h03;
    chk16("model_t5", model_csum(), pick(16'hEEFA, 16'hEF0E));
    send_pkt(99); drain();
    chk16("t5_csum", last_csum, pick(16'hEEFA, 16'hEF0E));

    // Three back-to-back single-beat packets under m_rdy toggling and csum_full pulses.
    p0 = pulses;
    mode = 1;
    for (int p = 0; p < 3; p++) begin
      clear_pkt(8); pkt[0] = 8'(p + 1); pkt[7] = 8'(8'h5A + p);
      send_pkt(99);
    end
    drain();
    mode = 0;
    chk_int("b2b_pulses", pulses - p0, 3);
    chk16("b2b_csum", last_csum, pick(16'hFFFF, 16'h0014));
    repeat (2) @(posedge clk); #1;

    // Reset after the third beat of a 7-beat packet.
    clear_pkt(56); pkt[34] = 8'h12; pkt[35] = 8'h34;
    p0 = pulses;
    send_pkt(3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_bit("midrst_s_rdy", bus.s_rdy, 1'b0);
    chk_bit("midrst_m_valid", bus.m_valid, 1'b0);
    chk_dat("midrst_m_dout", bus.m_dout, '0);
    chk_bit("midrst_csum_valid", bus.csum_valid, 1'b0);
    chk16("midrst_csum_data", bus.csum_data, 16'h0000);
    exp_beats.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(posedge clk); #1;
    chk_int("midrst_no_csum", pulses - p0, 0);
    send_pkt(99); drain();
    chk16("after_rst_csum", last_csum, pick(16'hEDCB, 16'hEDDF));
    chk_int("after_rst_pulses", pulses - p0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
